cordic_mult_scheduler: RTL and testbench
========================================

// Module: cordic_mult_scheduler
// PURPOSE
//  Shares one signed fixed-point multiplier (optional negate, rescale by >>FRAC_SIZE) among N_REQ requesters.
//  Typical requesters: the CORDIC rotation gain-compensation stages for the X and Y channels.
//  Round-robin arbitration, valid/ready on every request port, pipelined multiply.
//  Each result carries the ID of the requester that issued it.
// PARAMETERS
//  INT_SIZE    16  integer bits of the Q format
//  FRAC_SIZE   16  fraction bits; DW = INT_SIZE+FRAC_SIZE
//  N_REQ        2  number of requesters (>=2)
//  MUL_STAGES   2  multiplier pipeline depth (>=1)
//  ID_W (local)    max(1,$clog2(N_REQ))
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   N_REQ      request i presents operands
//  req_ready  out  N_REQ      one-hot grant; the request is accepted when valid&ready
//  req_a      in   N_REQ*DW   signed operand A; slice i = [i*DW +: DW]
//  req_b      in   N_REQ*DW   signed operand B; same slicing
//  req_neg    in   N_REQ      1 -> result is -(a*b)
//  res_valid  out  1          result available
//  res_ready  in   1          consumer accepts the result
//  res_id     out  ID_W       requester index of the result
//  res_data   out  DW         signed Q result
//  busy       out  1          any pipeline stage holds valid data
// BEHAVIOUR
//  Reset:
//   - all stage valids=0, res_valid=0, res_id=0, res_data=0, busy=0, req_ready=0.
//   - RR pointer = N_REQ-1, so index 0 has first priority.
//  Advance:
//   - adv = !res_valid | res_ready; it is a global stall.
//   - When adv=0: every stage holds, req_ready=0, res_* stable.
//  Arbitration:
//   - Combinational. With adv=1, grant the first i with req_valid[i]=1, searching from ptr+1 upward with wrap.
//   - req_ready = onehot(grant) when adv=1, else 0.
//   - ptr <= granted index only on acceptance; no request leaves ptr unchanged.
//   - At most one acceptance per cycle. Requesters hold operands until accepted.
//   - req_ready never depends on the requester's own ready.
//  Datapath:
//   - prod = a*b, signed, 2*DW bits. If neg, prod = -prod.
//     The -2^(DW-1) * -2^(DW-1) case fits in 2*DW bits and needs no special handling.
//   - res = prod >>> FRAC_SIZE (arithmetic shift), keeping the low DW bits (wraps).
//  Latency:
//   - Acceptance at edge k gives res_valid=1 after edge k+MUL_STAGES, with no stalls.
//   - Each stall cycle adds one cycle.
//   - Back-to-back acceptances give one result per cycle.
//   - Results leave in acceptance order; res_id/res_data belong to the same request.
//  Pipeline occupancy:
//   - Empty stages are still valid-gated bubbles; the pipeline is not compacted while stalled.
//   - busy = OR of all stage valids, including the output register.
//  Boundary conditions:
//   - Simultaneous final-stage drain and new acceptance is allowed (adv=1).
//   - req_valid dropped before acceptance is legal; nothing is captured.
//   - rst mid-operation discards all in-flight results; no partial output.
// CONFIGURATION
//  SAT_EN defined:
//   - the shifted result saturates to [-2^(DW-1), 2^(DW-1)-1] instead of wrapping.
//   - Saturation is decided on the full 2*DW-FRAC_SIZE-bit shifted value.
//   - Latency is unchanged.
//  SAT_EN undefined: wrap as described above.
// TESTING (DW=32, FRAC=16, MUL_STAGES=2)
//  1) Req0 a=0x00018000, b=0x00020000, neg=0, res_ready=1.
//     -> res_valid 2 cycles after acceptance; res_data=0x00030000, res_id=0.
//  2) Req1 a=0x00010000, b=0x00008000, neg=1.
//     -> res_data=0xFFFF8000, res_id=1.
//  3) Both requesters valid for 6 cycles, res_ready=1.
//     -> grants 0,1,0,1,0,1; res_id stream 0,1,0,1,0,1.
//  4) Pipeline full, res_ready=0 for 3 cycles.
//     -> res_data/res_id stable, req_ready=0; the stream resumes in order with no loss or duplication.
//  5) rst pulsed with 2 requests in flight.
//     -> res_valid=0 and busy=0 immediately; no stale result after release.
//  6) a=0x7FFF0000, b=0x00020000.
//     -> 0x7FFFFFFF with SAT_EN; 0xFFFE0000 without.

Source files
------------

// File: rtl/cordic_mult_scheduler.sv
// Round-robin shared signed Q multiplier (optional negate, >>>FRAC_SIZE); `SAT_EN selects saturation over wrap.
// Latency: result valid MUL_STAGES cycles after acceptance, one result per cycle when streaming.
// Backpressure: res_ready low stalls every stage globally and forces req_ready to zero.
module cordic_mult_scheduler #(
  parameter int INT_SIZE   = 16,
  parameter int FRAC_SIZE  = 16,
  parameter int N_REQ      = 2,
  parameter int MUL_STAGES = 2,
  localparam int DW        = INT_SIZE + FRAC_SIZE,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ-1:0]    req_neg,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ID_W-1:0]     res_id,
  output logic [DW-1:0]       res_data,
  output logic                busy
);

  logic            adv;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr;
  logic [N_REQ-1:0] gnt_oh;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            sel_neg;

  // operand stage
  logic                   s0_vld;
  logic [ID_W-1:0]        s0_id;
  logic signed [DW-1:0]   s0_a;
  logic signed [DW-1:0]   s0_b;
  logic                   s0_neg;

  // result delay chain; the last entry is the output register
  logic [MUL_STAGES-1:0]  st_vld;
  logic [ID_W-1:0]        st_id  [MUL_STAGES];
  logic [DW-1:0]          st_dat [MUL_STAGES];

  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] prod_n;
  logic signed [2*DW-1:0] shifted;
  logic [DW-1:0]          mul_res;

  assign adv = !res_valid || res_ready;

  // Scan offsets from farthest to nearest so the nearest valid requester after ptr wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && (((int'(ptr) + off) % N_REQ) == i)) begin
          found   = 1'b1;
          gnt_idx = ID_W'(i);
        end
      end
    end
  end

  assign accept = adv && found && !rst;

  always_comb begin
    gnt_oh  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_neg = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && (gnt_idx == ID_W'(i))) begin
        gnt_oh[i] = 1'b1;
        sel_a     = req_a[i*DW +: DW];
        sel_b     = req_b[i*DW +: DW];
        sel_neg   = req_neg[i];
      end
    end
  end

  assign req_ready = gnt_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= ID_W'(N_REQ - 1);
      s0_vld <= 1'b0;
      s0_id  <= '0;
      s0_a   <= '0;
      s0_b   <= '0;
      s0_neg <= 1'b0;
    end else begin
      if (accept) begin
        ptr <= gnt_idx;
      end
      if (adv) begin
        s0_vld <= accept;
        if (accept) begin
          s0_id  <= gnt_idx;
          s0_a   <= sel_a;
          s0_b   <= sel_b;
          s0_neg <= sel_neg;
        end
      end
    end
  end

  // Full-width signed product; min*min still fits, so negation never overflows.
  assign prod    = (2*DW)'(s0_a) * (2*DW)'(s0_b);
  assign prod_n  = s0_neg ? -prod : prod;
  assign shifted = prod_n >>> FRAC_SIZE;

`ifdef SAT_EN
  always_comb begin
    mul_res = shifted[DW-1:0];
    if (!((&shifted[2*DW-1:DW-1]) || !(|shifted[2*DW-1:DW-1]))) begin
      mul_res = shifted[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[2*DW-1:DW];
  assign mul_res   = shifted[DW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_vld <= '0;
      for (int s = 0; s < MUL_STAGES; s++) begin
        st_id[s]  <= '0;
        st_dat[s] <= '0;
      end
    end else if (adv) begin
      st_vld[0] <= s0_vld;
      st_id[0]  <= s0_id;
      st_dat[0] <= mul_res;
      for (int s = 1; s < MUL_STAGES; s++) begin
        st_vld[s] <= st_vld[s-1];
        st_id[s]  <= st_id[s-1];
        st_dat[s] <= st_dat[s-1];
      end
    end
  end

  assign res_valid = st_vld[MUL_STAGES-1];
  assign res_id    = st_id[MUL_STAGES-1];
  assign res_data  = st_dat[MUL_STAGES-1];
  assign busy      = s0_vld || (|st_vld);

endmodule

// File: tb/tb_cordic_mult_scheduler.sv
// Directed bench for cordic_mult_scheduler at DW=32, FRAC=16, N_REQ=2, MUL_STAGES=2.
module tb_cordic_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_neg;
  logic        res_valid;
  logic        res_ready;
  logic [0:0]  res_id;
  logic [31:0] res_data;
  logic        busy;

  int vectors = 0;
  int errs    = 0;
  logic [31:0] qd[$];
  logic [0:0]  qid[$];

`ifdef SAT_EN
  localparam logic [31:0] EXP_BIG  = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_MIN  = 32'h7FFFFFFF;
  localparam logic [31:0] EXP_MINN = 32'h80000000;
`else
  localparam logic [31:0] EXP_BIG  = 32'hFFFE0000;
  localparam logic [31:0] EXP_MIN  = 32'h00000000;
  localparam logic [31:0] EXP_MINN = 32'h00000000;
`endif

  cordic_mult_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_neg(req_neg),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consumer side: any result handed over at the coming edge is checked against the queue.
  task automatic tick();
    if (res_valid && res_ready) begin
      if (qd.size() == 0) begin
        errs++;
        $error("FAIL unexpected_result observed id=%0d data=%h expected none", res_id, res_data);
      end else begin
        chk("res_id", 64'(res_id), 64'(qid[0]));
        chk("res_data", 64'(res_data), 64'(qd[0]));
        void'(qd.pop_front());
        void'(qid.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic neg);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_neg[i]        = neg;
  endtask

  task automatic push(input logic [0:0] id, input logic [31:0] d);
    qid.push_back(id);
    qd.push_back(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_neg = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    #1;

    // 1) 1.5 * 2.0 from requester 0
    set_req(0, 32'h00018000, 32'h00020000, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("t1_grant", 64'(req_ready), 64'h1);
    push(1'b0, 32'h00030000);
    tick();
    req_valid = '0;
    chk("t1_lat0_valid", 64'(res_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_lat1_valid", 64'(res_valid), 64'd0);
    tick();
    chk("t1_lat2_valid", 64'(res_valid), 64'd1);
    tick();
    chk("t1_drain_valid", 64'(res_valid), 64'd0);
    chk("t1_drain_busy", 64'(busy), 64'd0);

    // 2) -(1.0 * 0.5) from requester 1
    set_req(1, 32'h00010000, 32'h00008000, 1'b1);
    req_valid = 2'b10;
    #1;
    chk("t2_grant", 64'(req_ready), 64'h2);
    push(1'b1, 32'hFFFF8000);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t2_lat2_valid", 64'(res_valid), 64'd1);
    tick();
    chk("t2_drain_valid", 64'(res_valid), 64'd0);

    // 3) both requesters contend for six cycles
    for (int c = 0; c < 6; c++) begin
      set_req(0, 32'((c + 1) << 16), 32'h00010000, 1'b0);
      set_req(1, 32'((c + 11) << 16), 32'h00010000, 1'b0);
      req_valid = 2'b11;
      #1;
      if (c % 2 == 0) begin
        chk("t3_grant0", 64'(req_ready), 64'h1);
        push(1'b0, 32'((c + 1) << 16));
      end else begin
        chk("t3_grant1", 64'(req_ready), 64'h2);
        push(1'b1, 32'((c + 11) << 16));
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("t3_all_results", 64'(qd.size()), 64'd0);
    chk("t3_idle", 64'(res_valid), 64'd0);

    // 4) fill the pipe, then stall the consumer for three cycles
    set_req(0, 32'h00050000, 32'h00010000, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("t4_grant_a", 64'(req_ready), 64'h1);
    push(1'b0, 32'h00050000);
    tick();
    set_req(1, 32'h00060000, 32'h00010000, 1'b0);
    req_valid = 2'b10;
    #1;
    chk("t4_grant_b", 64'(req_ready), 64'h2);
    push(1'b1, 32'h00060000);
    tick();
    set_req(0, 32'h00070000, 32'h00010000, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("t4_grant_c", 64'(req_ready), 64'h1);
    push(1'b0, 32'h00070000);
    tick();
    res_ready = 1'b0;
    set_req(0, 32'h00080000, 32'h00010000, 1'b0);
    req_valid = 2'b01;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("t4_stall_ready", 64'(req_ready), 64'h0);
      chk("t4_stall_valid", 64'(res_valid), 64'd1);
      chk("t4_stall_data", 64'(res_data), 64'h00050000);
      chk("t4_stall_id", 64'(res_id), 64'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("t4_grant_d", 64'(req_ready), 64'h1);
    push(1'b0, 32'h00080000);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("t4_all_results", 64'(qd.size()), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);

    // 5) reset with two requests in flight
    set_req(0, 32'h00010000, 32'h00010000, 1'b0);
    req_valid = 2'b01;
    tick();
    set_req(1, 32'h00020000, 32'h00010000, 1'b0);
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    chk("t5_inflight_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(res_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("t5_no_stale", 64'(res_valid), 64'd0);
    end

    // 6) overflow: wrap vs saturate, including min*min with and without negate
    set_req(0, 32'h7FFF0000, 32'h00020000, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("t6_grant_big", 64'(req_ready), 64'h1);
    push(1'b0, EXP_BIG);
    tick();
    set_req(1, 32'h80000000, 32'h80000000, 1'b0);
    req_valid = 2'b10;
    #1;
    chk("t6_grant_min", 64'(req_ready), 64'h2);
    push(1'b1, EXP_MIN);
    tick();
    set_req(0, 32'h80000000, 32'h80000000, 1'b1);
    req_valid = 2'b01;
    #1;
    chk("t6_grant_minn", 64'(req_ready), 64'h1);
    push(1'b0, EXP_MINN);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("t6_all_results", 64'(qd.size()), 64'd0);
    chk("t6_idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
